// File: rtl/io_input_conditioner.sv
// Board input conditioning: per-bit synchroniser + debouncer, then a sticky
// button-press latch and saturating press counter on the processor IO bus.

module io_debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int CNT_W           = 17
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic clean
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1, s2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      clean <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      // any cycle agreeing with the clean value restarts the qualification
      if (s2 == clean) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        clean <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end
endmodule

module io_input_conditioner #(
  parameter int N_BTN           = 5,
  parameter int N_SW            = 16,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int CNT_W           = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic [N_SW-1:0]  sw_raw,
  output logic [N_BTN-1:0] btn_clean,
  output logic [N_SW-1:0]  sw_clean,
  input  logic [31:0]      io_addr,
  input  logic [31:0]      io_wr_val,
  input  logic             io_write_en,
  input  logic             io_read_en,
  output logic [31:0]      io_rd_val,
  output logic             io_hit
);
  localparam int          NT         = N_BTN + N_SW;
  localparam logic [31:0] ADDR_PRESS = 32'h0002_000C;
  localparam logic [31:0] ADDR_CNT   = 32'h0002_0010;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
  } io_req_t;

  io_req_t req;
  assign req = '{addr: io_addr, wdata: io_wr_val, we: io_write_en};

  logic [NT-1:0] raw_all, clean_all;
  assign raw_all = {sw_raw, btn_raw};

  genvar i;
  generate
    for (i = 0; i < NT; i++) begin : g_db
      io_debounce_bit #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
      ) u_db (
        .clk  (clk),
        .rst  (rst),
        .raw  (raw_all[i]),
        .clean(clean_all[i])
      );
    end
  endgenerate

  assign btn_clean = clean_all[N_BTN-1:0];
  assign sw_clean  = clean_all[NT-1:N_BTN];

  logic [N_BTN-1:0] btn_prev, press, rise, clr;
  logic [7:0]       press_cnt;
  logic             wr_press, wr_cnt;

  assign rise     = btn_clean & ~btn_prev;
  assign wr_press = req.we && (req.addr == ADDR_PRESS);
  assign wr_cnt   = req.we && (req.addr == ADDR_CNT);
  assign clr      = wr_press ? req.wdata[N_BTN-1:0] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_prev  <= '0;
      press     <= '0;
      press_cnt <= '0;
    end else begin
      btn_prev <= btn_clean;
      // OR-ing rise after the clear lets a new press beat a same-cycle W1C
      press    <= (press & ~clr) | rise;
      if (wr_cnt)
        press_cnt <= '0;
      else if ((|rise) && (press_cnt != 8'hFF))
        press_cnt <= press_cnt + 8'd1;
    end
  end

  always_comb begin
    io_rd_val = '0;
    io_hit    = 1'b0;
    if (req.addr == ADDR_PRESS) begin
      io_rd_val[N_BTN-1:0] = press;
      io_hit               = 1'b1;
    end else if (req.addr == ADDR_CNT) begin
      io_rd_val[7:0] = press_cnt;
      io_hit         = 1'b1;
    end
  end

  // reads are decoded purely from the address; the strobe carries no state
  logic unused_ok;
  assign unused_ok = ^{io_read_en, req};
endmodule

// File: tb/tb_io_input_conditioner.sv
// Directed + randomized bench for io_input_conditioner with a window-based
// reference model of debounce, press latch and press counter.

module tb_io_input_conditioner;
  localparam int NB = 5;
  localparam int NS = 16;
  localparam int NT = NB + NS;
  localparam int D  = 8;
  localparam logic [31:0] A_PRESS = 32'h0002_000C;
  localparam logic [31:0] A_CNT   = 32'h0002_0010;

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] btn_raw, btn_clean;
  logic [NS-1:0] sw_raw, sw_clean;
  logic [31:0]   io_addr, io_wr_val, io_rd_val;
  logic          io_write_en, io_read_en, io_hit;

  int n_tests = 0;
  int n_fail  = 0;

  io_input_conditioner #(
    .N_BTN(NB), .N_SW(NS), .DEBOUNCE_CYCLES(D), .CNT_W(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .sw_raw     (sw_raw),
    .btn_clean  (btn_clean),
    .sw_clean   (sw_clean),
    .io_addr    (io_addr),
    .io_wr_val  (io_wr_val),
    .io_write_en(io_write_en),
    .io_read_en (io_read_en),
    .io_rd_val  (io_rd_val),
    .io_hit     (io_hit)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  // Reference model: sampled raw history; a bit flips once the last D
  // samples that have passed the two sync stages all disagree with it.
  logic [NT-1:0] hq[$];
  logic [NT-1:0] m_clean;
  logic [NB-1:0] m_press, m_prev;
  int            m_cnt;

  task automatic model_edge();
    logic [NB-1:0] rise, clr;
    logic [NT-1:0] nc, e;
    bit            diff;
    if (rst) begin
      hq.delete();
      repeat (D + 2) hq.push_back('0);
      m_clean = '0; m_press = '0; m_prev = '0; m_cnt = 0;
    end else begin
      rise = m_clean[NB-1:0] & ~m_prev;
      clr  = (io_write_en && io_addr == A_PRESS) ? io_wr_val[NB-1:0] : '0;
      m_press = (m_press & ~clr) | rise;
      if (io_write_en && io_addr == A_CNT) m_cnt = 0;
      else if (rise != 0 && m_cnt < 255) m_cnt = m_cnt + 1;
      m_prev = m_clean[NB-1:0];
      hq.push_back({sw_raw, btn_raw});
      void'(hq.pop_front());
      nc = m_clean;
      for (int b = 0; b < NT; b++) begin
        diff = 1'b1;
        for (int j = 0; j < D; j++) begin
          e = hq[j];
          if (e[b] == m_clean[b]) diff = 1'b0;
        end
        if (diff) nc[b] = ~m_clean[b];
      end
      m_clean = nc;
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    if (a == A_PRESS) return {27'b0, m_press};
    if (a == A_CNT)   return m_cnt;
    return 32'h0;
  endfunction

  function automatic logic [31:0] model_hit(input logic [31:0] a);
    return (a == A_PRESS || a == A_CNT) ? 32'h1 : 32'h0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("btn_clean", {27'b0, btn_clean}, {27'b0, m_clean[NB-1:0]});
    chk("sw_clean", {16'b0, sw_clean}, {16'b0, m_clean[NT-1:NB]});
    chk("rd_val", io_rd_val, model_rd(io_addr));
    chk("hit", {31'b0, io_hit}, model_hit(io_addr));
  endtask

  task automatic cycn(input int n);
    repeat (n) cyc();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    io_addr = a; io_wr_val = d; io_write_en = 1'b1;
    cyc();
    io_write_en = 1'b0; io_wr_val = '0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    io_addr = a;
    #1;
    chk(tag, io_rd_val, exp);
    chk({tag, "_model"}, io_rd_val, model_rd(a));
    chk({tag, "_hit"}, {31'b0, io_hit}, model_hit(a));
  endtask

  initial begin
    bit seen;
    int h;
    rst = 1'b1; btn_raw = '0; sw_raw = 16'hFFFF;
    io_addr = '0; io_wr_val = '0; io_write_en = 1'b0; io_read_en = 1'b0;
    repeat (D + 2) hq.push_back('0);
    m_clean = '0; m_press = '0; m_prev = '0; m_cnt = 0;

    // 1: reset with switches high, release, exact latency
    cycn(2);
    chk("t1_rst_sw", {16'b0, sw_clean}, 32'h0);
    rd("t1_rst_press", A_PRESS, 32'h0);
    rd("t1_rst_cnt", A_CNT, 32'h0);
    rst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      chk($sformatf("t1_sw_edge%0d", k), {16'b0, sw_clean}, (k >= 10) ? 32'hFFFF : 32'h0);
    end
    sw_raw = '0;
    cycn(12);

    // 2: glitch restarts the count
    btn_raw[0] = 1'b1;
    for (int k = 0; k < 7; k++) begin cyc(); chk("t2_pre", {31'b0, btn_clean[0]}, 32'h0); end
    btn_raw[0] = 1'b0;
    cyc(); chk("t2_glitch", {31'b0, btn_clean[0]}, 32'h0);
    btn_raw[0] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      chk($sformatf("t2_edge%0d", k), {31'b0, btn_clean[0]}, (k >= 10) ? 32'h1 : 32'h0);
    end
    btn_raw[0] = 1'b0;
    cycn(12);

    // 3: press latch W1C
    wr(A_PRESS, 32'hFFFF_FFFF);
    rd("t3_cleared", A_PRESS, 32'h0);
    btn_raw[2] = 1'b1; cycn(12);
    btn_raw[2] = 1'b0; cycn(12);
    rd("t3_press2", A_PRESS, 32'h4);
    wr(A_PRESS, 32'h1);
    rd("t3_w1c_other", A_PRESS, 32'h4);
    wr(A_PRESS, 32'h4);
    rd("t3_w1c_own", A_PRESS, 32'h0);

    // 4: set beats same-cycle clear
    btn_raw[1] = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      cyc();
      if (btn_clean[1]) seen = 1'b1;
    end
    if (!seen) begin
      n_tests++; n_fail++;
      $error("FAIL t4_timeout: observed btn_clean[1]=0 expected 1 within 30 cycles");
    end
    wr(A_PRESS, 32'h2);
    rd("t4_set_wins", A_PRESS, 32'h2);
    btn_raw[1] = 1'b0; cycn(12);

    // 5: saturating counter, randomized press patterns
    wr(A_CNT, 32'h0);
    rd("t5_cnt_clr", A_CNT, 32'h0);
    for (int p = 0; p < 300; p++) begin
      btn_raw = NB'($urandom_range(1, 31));
      h = $urandom_range(10, 14);
      cycn(h);
      btn_raw = '0;
      h = $urandom_range(10, 14);
      cycn(h);
    end
    rd("t5_sat", A_CNT, 32'hFF);
    wr(A_CNT, 32'h0);
    btn_raw = 5'b01001; cycn(12);
    btn_raw = '0;       cycn(12);
    rd("t5_same_cycle", A_CNT, 32'h1);
    wr(A_CNT, $urandom);
    rd("t5_wr_any", A_CNT, 32'h0);
    wr(32'h0002_0008, 32'hFFFF_FFFF);
    rd("t5_nomatch", 32'h0002_0008, 32'h0);
    rd("t5_press_kept", A_PRESS, model_rd(A_PRESS));

    // randomized switch activity with short and long holds
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 5) == 0) sw_raw = sw_raw ^ NS'($urandom);
      cyc();
    end
    sw_raw = '0;
    cycn(12);

    // 6: reset in the middle of a debounce
    btn_raw[4] = 1'b1;
    cycn(7);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("t6_clean", {27'b0, btn_clean}, 32'h0);
    rd("t6_press", A_PRESS, 32'h0);
    rd("t6_cnt", A_CNT, 32'h0);
    for (int k = 1; k <= 12; k++) begin
      cyc();
      chk($sformatf("t6_edge%0d", k), {31'b0, btn_clean[4]}, (k >= 10) ? 32'h1 : 32'h0);
    end
    rd("t6_held_press", A_PRESS, 32'h10);
    rd("t6_held_cnt", A_CNT, 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
